// File: rtl/smoldvi_symbol_aligner_if.sv
// Lane-side bundle for the TMDS symbol aligner: DDR bit pair and resync in,
// aligned symbol stream with lock status and FSM state out.
interface smoldvi_symbol_aligner_if;
    logic       d_rise;
    logic       d_fall;
    logic       force_resync;
    logic [9:0] sym;
    logic       sym_valid;
    logic       sym_is_ctrl;
    logic [1:0] sym_ctrl;
    logic       locked;
    logic [3:0] offset;
    logic       dbg_state;

    // sym_valid is a ready-less strobe: the consumer must take sym, sym_is_ctrl
    // and sym_ctrl in the single cycle sym_valid is high; there is no backpressure.
    modport master (
        output d_rise, d_fall, force_resync,
        input  sym, sym_valid, sym_is_ctrl, sym_ctrl, locked, offset, dbg_state
    );
    modport slave (
        input  d_rise, d_fall, force_resync,
        output sym, sym_valid, sym_is_ctrl, sym_ctrl, locked, offset, dbg_state
    );
endinterface

// File: rtl/smoldvi_symbol_aligner.sv
// Assembles 10-bit TMDS symbols from a 2-bit-per-cycle DDR stream and hunts for
// the symbol boundary by bit-slipping until control tokens line up.
module smoldvi_symbol_aligner #(
    parameter int HUNT_TIMEOUT = 1024,
    parameter int LOCK_COUNT   = 8,
    parameter int LOSS_TIMEOUT = 4096
) (
    input  logic                      clk_x5,
    input  logic                      rst_n_x5,
    smoldvi_symbol_aligner_if.slave   bus
);
    localparam int HuntW = $clog2(HUNT_TIMEOUT + 1);
    localparam int RunW  = $clog2(LOCK_COUNT + 1);
    localparam int LossW = $clog2(LOSS_TIMEOUT + 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [19:0]      sreg_q, sreg_d;
    logic [2:0]       phase_q, phase_d;
    logic [3:0]       offset_q, offset_d;
    logic [9:0]       sym_q, sym_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_is_ctrl_q, sym_is_ctrl_d;
    logic [1:0]       sym_ctrl_q, sym_ctrl_d;
    logic             locked_q, locked_d;
    logic [HuntW-1:0] miss_ctr_q, miss_ctr_d;
    logic [RunW-1:0]  run_ctr_q, run_ctr_d;
    logic [LossW-1:0] loss_ctr_q, loss_ctr_d;

    logic [9:0]       window;
    logic [2:0]       decoded;
    logic [HuntW-1:0] miss_inc;
    logic [RunW-1:0]  run_inc;
    logic [LossW-1:0] loss_inc;

    function automatic logic [2:0] ctrl_decode(input logic [9:0] s);
        case (s)
            10'b1101010100: return 3'b100;
            10'b0010101011: return 3'b101;
            10'b0101010100: return 3'b110;
            10'b1010101011: return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    function automatic logic [3:0] bump_offset(input logic [3:0] o);
        return (o >= 4'd9) ? 4'd0 : o + 4'd1;
    endfunction

    // sreg[0] is the oldest bit, so the window at offset N starts N bits later on the wire.
    always_comb begin
        case (offset_q)
            4'd0:    window = sreg_q[9:0];
            4'd1:    window = sreg_q[10:1];
            4'd2:    window = sreg_q[11:2];
            4'd3:    window = sreg_q[12:3];
            4'd4:    window = sreg_q[13:4];
            4'd5:    window = sreg_q[14:5];
            4'd6:    window = sreg_q[15:6];
            4'd7:    window = sreg_q[16:7];
            4'd8:    window = sreg_q[17:8];
            4'd9:    window = sreg_q[18:9];
            default: window = sreg_q[9:0];
        endcase
    end

    always_comb begin
        sreg_d        = {bus.d_fall, bus.d_rise, sreg_q[19:2]};
        phase_d       = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        sym_valid_d   = (phase_q == 3'd4);
        sym_d         = sym_q;
        sym_is_ctrl_d = sym_is_ctrl_q;
        sym_ctrl_d    = sym_ctrl_q;
        decoded       = ctrl_decode(window);
        if (phase_q == 3'd4) begin
            sym_d         = window;
            sym_is_ctrl_d = decoded[2];
            sym_ctrl_d    = decoded[1:0];
        end
    end

    assign miss_inc = (miss_ctr_q == HuntW'(HUNT_TIMEOUT)) ? miss_ctr_q : miss_ctr_q + HuntW'(1);
    assign run_inc  = (run_ctr_q == RunW'(LOCK_COUNT))     ? run_ctr_q  : run_ctr_q + RunW'(1);
    assign loss_inc = (loss_ctr_q == LossW'(LOSS_TIMEOUT)) ? loss_ctr_q : loss_ctr_q + LossW'(1);

    // The FSM looks at the registered symbol, i.e. on the cycle sym_valid is high.
    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        miss_ctr_d = miss_ctr_q;
        run_ctr_d  = run_ctr_q;
        loss_ctr_d = loss_ctr_q;
        if (sym_valid_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (sym_is_ctrl_q) begin
                        miss_ctr_d = '0;
                        run_ctr_d  = run_inc;
                        if (run_inc == RunW'(LOCK_COUNT)) begin
                            state_d    = ST_LOCKED;
                            loss_ctr_d = '0;
                        end
                    end else begin
                        run_ctr_d = '0;
                        if (miss_inc == HuntW'(HUNT_TIMEOUT)) begin
                            offset_d   = bump_offset(offset_q);
                            miss_ctr_d = '0;
                        end else begin
                            miss_ctr_d = miss_inc;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sym_is_ctrl_q) begin
                        loss_ctr_d = '0;
                    end else begin
                        loss_ctr_d = loss_inc;
                        if (loss_inc == LossW'(LOSS_TIMEOUT)) begin
                            state_d    = ST_HUNT;
                            run_ctr_d  = '0;
                            miss_ctr_d = '0;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
        if (bus.force_resync) begin
            state_d    = ST_HUNT;
            offset_d   = bump_offset(offset_q);
            miss_ctr_d = '0;
            run_ctr_d  = '0;
            loss_ctr_d = '0;
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk_x5 or negedge rst_n_x5) begin
        if (!rst_n_x5) begin
            state_q       <= ST_HUNT;
            sreg_q        <= '0;
            phase_q       <= '0;
            offset_q      <= '0;
            sym_q         <= '0;
            sym_valid_q   <= 1'b0;
            sym_is_ctrl_q <= 1'b0;
            sym_ctrl_q    <= '0;
            locked_q      <= 1'b0;
            miss_ctr_q    <= '0;
            run_ctr_q     <= '0;
            loss_ctr_q    <= '0;
        end else begin
            state_q       <= state_d;
            sreg_q        <= sreg_d;
            phase_q       <= phase_d;
            offset_q      <= offset_d;
            sym_q         <= sym_d;
            sym_valid_q   <= sym_valid_d;
            sym_is_ctrl_q <= sym_is_ctrl_d;
            sym_ctrl_q    <= sym_ctrl_d;
            locked_q      <= locked_d;
            miss_ctr_q    <= miss_ctr_d;
            run_ctr_q     <= run_ctr_d;
            loss_ctr_q    <= loss_ctr_d;
        end
    end

    assign bus.sym         = sym_q;
    assign bus.sym_valid   = sym_valid_q;
    assign bus.sym_is_ctrl = sym_is_ctrl_q;
    assign bus.sym_ctrl    = sym_ctrl_q;
    assign bus.locked      = locked_q;
    assign bus.offset      = offset_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_smoldvi_symbol_aligner.sv
// Bench for smoldvi_symbol_aligner: wire-bit history plus a behavioural lock model
// feed an expected-symbol queue; strobes pop and compare, status is compared every cycle.
module tb_smoldvi_symbol_aligner;
  localparam int HUNT_T = 4;
  localparam int LOCK_C = 8;
  localparam int LOSS_T = 4096;
  localparam logic [9:0] TOK00 = 10'b1101010100;
  localparam logic [9:0] TOK01 = 10'b0010101011;
  localparam logic [9:0] TOK10 = 10'b0101010100;
  localparam logic [9:0] TOK11 = 10'b1010101011;
  localparam logic [9:0] DATA  = 10'h155;

  logic clk_x5 = 1'b0;
  logic rst_n_x5 = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk_x5 = ~clk_x5;

  smoldvi_symbol_aligner_if bus ();

  smoldvi_symbol_aligner #(
    .HUNT_TIMEOUT(HUNT_T),
    .LOCK_COUNT(LOCK_C),
    .LOSS_TIMEOUT(LOSS_T)
  ) dut (
    .clk_x5(clk_x5),
    .rst_n_x5(rst_n_x5),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- model / scoreboard state ----------------
  logic [12:0] exp_q[$];
  bit hist[$];
  bit tx_q[$];
  logic [9:0] cur_word;
  int edge_n;
  int m_phase, m_offset, m_run, m_miss, m_loss;
  bit m_locked, m_valid, m_last_ctrl;
  int force_mode;
  bit force_fired;
  bit prev_locked;
  int prev_off;
  int fall_cnt, fall_off, wrap_cnt, inc_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_decode(input logic [9:0] s);
    if (s == TOK00) return 3'b100;
    if (s == TOK01) return 3'b101;
    if (s == TOK10) return 3'b110;
    if (s == TOK11) return 3'b111;
    return 3'b000;
  endfunction

  // At capture edge e the register holds wire bits 2e-22 .. 2e-3.
  function automatic logic [9:0] ref_window(input int e, input int off);
    logic [9:0] w;
    int idx;
    w = '0;
    for (int b = 0; b < 10; b++) begin
      idx = 2 * e - 22 + off + b;
      if (idx >= 0 && idx < hist.size()) w[b] = hist[idx];
    end
    return w;
  endfunction

  task automatic model_edge(input bit fr);
    int n_phase;
    bit n_valid, n_last;
    logic [9:0] w;
    logic [2:0] dec;
    n_phase = (m_phase == 4) ? 0 : m_phase + 1;
    n_valid = (m_phase == 4);
    n_last = m_last_ctrl;
    if (m_phase == 4) begin
      w = ref_window(edge_n, m_offset);
      dec = ref_decode(w);
      exp_q.push_back({dec, w});
      n_last = dec[2];
    end
    if (fr) begin
      m_locked = 1'b0;
      m_run = 0;
      m_miss = 0;
      m_loss = 0;
      m_offset = (m_offset + 1) % 10;
    end else if (m_valid) begin
      if (!m_locked) begin
        if (m_last_ctrl) begin
          m_miss = 0;
          if (m_run < LOCK_C) m_run++;
          if (m_run == LOCK_C) begin
            m_locked = 1'b1;
            m_loss = 0;
          end
        end else begin
          m_run = 0;
          m_miss++;
          if (m_miss >= HUNT_T) begin
            m_miss = 0;
            m_offset = (m_offset == 9) ? 0 : m_offset + 1;
          end
        end
      end else begin
        if (m_last_ctrl) m_loss = 0;
        else begin
          if (m_loss < LOSS_T) m_loss++;
          if (m_loss == LOSS_T) begin
            m_locked = 1'b0;
            m_run = 0;
            m_miss = 0;
          end
        end
      end
    end
    m_phase = n_phase;
    m_valid = n_valid;
    m_last_ctrl = n_last;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    bit r, f, fr;
    logic [12:0] e;
    if (tx_q.size() < 2) for (int b = 0; b < 10; b++) tx_q.push_back(cur_word[b]);
    r = tx_q.pop_front();
    f = tx_q.pop_front();
    fr = 1'b0;
    if (force_mode == 1 && m_valid && m_last_ctrl && !m_locked && m_run == LOCK_C - 1) fr = 1'b1;
    if (force_mode == 2 && m_offset == 9) fr = 1'b1;
    bus.d_rise = r;
    bus.d_fall = f;
    bus.force_resync = fr;
    hist.push_back(r);
    hist.push_back(f);
    @(posedge clk_x5);
    edge_n++;
    model_edge(fr);
    @(negedge clk_x5);
    bus.force_resync = 1'b0;
    check_eq("sym_valid", bus.sym_valid, m_valid);
    check_eq("locked", bus.locked, m_locked);
    check_eq("offset", bus.offset, m_offset);
    check_eq("fsm_state", bus.dbg_state, m_locked);
    if (bus.sym_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sym_unexpected: got strobe with sym 0x%0h, expected none", bus.sym);
      end else begin
        e = exp_q.pop_front();
        check_eq("sym", bus.sym, e[9:0]);
        check_eq("sym_is_ctrl", bus.sym_is_ctrl, e[12]);
        check_eq("sym_ctrl", bus.sym_ctrl, e[11:10]);
      end
    end
    if (prev_locked && !bus.locked) begin
      fall_cnt++;
      fall_off = bus.offset;
    end
    if (!fr && prev_off == 9 && bus.offset == 0) wrap_cnt++;
    if (bus.offset == prev_off + 1) inc_cnt++;
    prev_locked = bus.locked;
    prev_off = bus.offset;
    if (fr && force_mode == 1) begin
      check_eq("resync_on_8th_locked", bus.locked, 0);
      check_eq("resync_on_8th_state", bus.dbg_state, 0);
      check_eq("resync_on_8th_offset", bus.offset, 1);
      force_fired = 1'b1;
      force_mode = 0;
    end
    if (fr && force_mode == 2) begin
      check_eq("resync_at_9_offset", bus.offset, 0);
      check_eq("resync_at_9_locked", bus.locked, 0);
      force_fired = 1'b1;
      force_mode = 0;
    end
  endtask

  task automatic send_word(input logic [9:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 10; b++) tx_q.push_back(w[b]);
      repeat (5) step();
    end
  endtask

  // Reset mid-stream; delay shifts the symbol boundary later on the wire.
  task automatic do_reset(input int delay);
    rst_n_x5 = 1'b0;
    #1;
    check_eq("async_rst_locked", bus.locked, 0);
    check_eq("async_rst_offset", bus.offset, 0);
    for (int i = 0; i < 4; i++) begin
      bus.d_rise = 1'($urandom_range(0, 1));
      bus.d_fall = 1'($urandom_range(0, 1));
      bus.force_resync = 1'($urandom_range(0, 1));
      @(negedge clk_x5);
      check_eq("rst_sym", bus.sym, 0);
      check_eq("rst_sym_valid", bus.sym_valid, 0);
      check_eq("rst_sym_is_ctrl", bus.sym_is_ctrl, 0);
      check_eq("rst_sym_ctrl", bus.sym_ctrl, 0);
      check_eq("rst_locked", bus.locked, 0);
      check_eq("rst_offset", bus.offset, 0);
    end
    bus.force_resync = 1'b0;
    rst_n_x5 = 1'b1;
    exp_q.delete();
    hist.delete();
    tx_q.delete();
    edge_n = 0;
    m_phase = 0; m_offset = 0; m_run = 0; m_miss = 0; m_loss = 0;
    m_locked = 1'b0; m_valid = 1'b0; m_last_ctrl = 1'b0;
    prev_locked = 1'b0; prev_off = 0;
    fall_cnt = 0; fall_off = -1; wrap_cnt = 0; inc_cnt = 0;
    force_mode = 0; force_fired = 1'b0;
    for (int i = 0; i < 8 + delay; i++) tx_q.push_back(1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int first_v, second_v;
    bus.d_rise = 1'b0;
    bus.d_fall = 1'b0;
    bus.force_resync = 1'b0;
    cur_word = TOK00;
    @(negedge clk_x5);

    // reset, first strobe and period
    do_reset(0);
    first_v = 0;
    second_v = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (bus.sym_valid && first_v == 0) first_v = c + 1;
      else if (bus.sym_valid && second_v == 0) second_v = c + 1;
    end
    check_eq("first_valid_cycle", first_v, 6);
    check_eq("valid_period", second_v - first_v, 5);

    // aligned TOK00 stream locks at offset 0
    send_word(TOK00, 20);
    check_eq("aligned_locked", bus.locked, 1);
    check_eq("aligned_offset", bus.offset, 0);

    // loss of lock: a token at loss count 4095 keeps lock, 4096 data drops it
    send_word(DATA, 4095);
    send_word(TOK00, 1);
    send_word(DATA, 4090);
    check_eq("loss_kept_falls", fall_cnt, 0);
    check_eq("loss_kept_locked", bus.locked, 1);
    send_word(DATA, 10);
    check_eq("loss_falls", fall_cnt, 1);
    check_eq("loss_fall_offset", fall_off, 0);

    // misaligned by 3 bits
    do_reset(3);
    cur_word = TOK01;
    send_word(TOK01, 30);
    check_eq("mis3_slips", inc_cnt, 3);
    check_eq("mis3_offset", bus.offset, 3);
    check_eq("mis3_locked", bus.locked, 1);

    // slip wrap 9 -> 0, then force_resync at offset 9
    do_reset(0);
    cur_word = DATA;
    send_word(DATA, 50);
    check_eq("slip_wrap_seen", (wrap_cnt != 0), 1);
    force_mode = 2;
    send_word(DATA, 60);
    check_eq("resync_at_9_fired", force_fired, 1);

    // force_resync on the 8th lock token
    do_reset(0);
    cur_word = TOK00;
    force_mode = 1;
    send_word(TOK00, 12);
    check_eq("resync_on_8th_fired", force_fired, 1);
    check_eq("resync_on_8th_end_locked", bus.locked, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
